// File: rtl/accel_pkg.sv
// Shared accelerator definitions: pixel format and unpool FSM state encoding.
// Pixels are 2*PIXEL_BITS wide, the same format the 2x2 max-pool stage emits.
package accel_pkg;

    localparam int unsigned PIXEL_BITS = 8;
    localparam int unsigned PIXEL_W    = 2 * PIXEL_BITS;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2
    } unpool_state_t;

endpackage

// File: rtl/unpool_linebuf.sv
// Line buffer holding one pooled input row.
// Ports: clk; we/waddr/wdata synchronous write; raddr/rdata combinational read.
// Contents are not reset.
module unpool_linebuf #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port
    assign rdata = mem[raddr];

endmodule

// File: rtl/unpool2x_stream.sv
// Streaming 2x2 nearest-neighbour upsampler.
// Buffers one pooled row (FILL), then emits it twice (EMIT0, EMIT1) with each
// pixel duplicated horizontally.
// Ports: clk, rst_n (sync, active-low);
//   in_valid/in_ready/in_data   : pooled pixel stream, row-major
//   out_valid/out_ready/out_data: upsampled pixel stream, row-major
//   out_sol  : out_data is column 0 of an output row
//   out_last : out_data is the final pixel of the frame
module unpool2x_stream
    import accel_pkg::*;
#(
    parameter int unsigned BITS = PIXEL_BITS,
    parameter int unsigned DIM  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*BITS-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*BITS-1:0] out_data,
    output logic              out_sol,
    output logic              out_last
);

    localparam int unsigned PW   = 2 * BITS;
    localparam int unsigned HALF = DIM / 2;
    localparam int unsigned ICW  = $clog2(HALF);
    localparam int unsigned OCW  = $clog2(DIM);

    unpool_state_t  state, state_n;
    logic [ICW-1:0] in_col, in_col_n;
    logic [OCW-1:0] out_col, out_col_n;
    logic [ICW-1:0] row, row_n;
    logic           in_ready_n, out_valid_n, out_sol_n, out_last_n;
    logic           accept, xfer, we;

    // State, counters and output flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            in_col    <= '0;
            out_col   <= '0;
            row       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sol   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state     <= state_n;
            in_col    <= in_col_n;
            out_col   <= out_col_n;
            row       <= row_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_sol   <= out_sol_n;
            out_last  <= out_last_n;
        end
    end

    // Next state; flags are derived from next-state values so they are
    // registered yet aligned with the cycle they describe.
    always_comb begin
        state_n   = state;
        in_col_n  = in_col;
        out_col_n = out_col;
        row_n     = row;
        accept    = in_valid & in_ready;
        xfer      = out_valid & out_ready;
        we        = 1'b0;

        case (state)
            FILL: begin
                if (accept) begin
                    we = 1'b1;
                    if (in_col == ICW'(HALF - 1)) begin
                        in_col_n = '0;
                        state_n  = EMIT0;
                    end else begin
                        in_col_n = in_col + ICW'(1);
                    end
                end
            end
            EMIT0: begin
                if (xfer) begin
                    if (out_col == OCW'(DIM - 1)) begin
                        out_col_n = '0;
                        state_n   = EMIT1;
                    end else begin
                        out_col_n = out_col + OCW'(1);
                    end
                end
            end
            EMIT1: begin
                if (xfer) begin
                    if (out_col == OCW'(DIM - 1)) begin
                        out_col_n = '0;
                        row_n     = (row == ICW'(HALF - 1)) ? '0 : row + ICW'(1);
                        state_n   = FILL;
                    end else begin
                        out_col_n = out_col + OCW'(1);
                    end
                end
            end
            default: begin
                state_n = FILL;
            end
        endcase

        in_ready_n  = (state_n == FILL);
        out_valid_n = (state_n != FILL);
        out_sol_n   = out_valid_n & (out_col_n == '0);
        out_last_n  = (state_n == EMIT1) & (row_n == ICW'(HALF - 1)) &
                      (out_col_n == OCW'(DIM - 1));
    end

    // Each buffered pixel feeds two adjacent output columns
    unpool_linebuf #(
        .W     (PW),
        .DEPTH (HALF),
        .AW    (ICW)
    ) u_linebuf (
        .clk   (clk),
        .we    (we),
        .waddr (in_col),
        .wdata (in_data),
        .raddr (ICW'(out_col >> 1)),
        .rdata (out_data)
    );

endmodule

// File: doc/unpool2x_stream.md
# unpool2x_stream

Streaming 2x2 nearest-neighbour upsampler; the inverse direction of the accelerator's 2x2 max-pool stage. Accepts a pooled (DIM/2)x(DIM/2) feature map as a row-major valid/ready stream of 2*BITS-wide pixels. Emits the DIM x DIM map as a second valid/ready stream: each input pixel is duplicated horizontally, and each input row is emitted twice. Used on the accelerator's decoder/back-propagation path to restore pooled maps to full resolution.

## Interface
- BITS, 8, base element width; pixels are 2*BITS wide, matching the pooled output format
- DIM, 32, output map dimension; even, >= 4; input map is DIM/2 x DIM/2
- clk, input, 1, single clock; all logic on rising edge
- rst_n, input, 1, synchronous, active-low reset
- in_valid, input, 1, upstream pixel valid
- in_ready, output, 1, block accepts a pixel this cycle
- in_data, input, 2*BITS, pooled pixel, row-major
- out_valid, output, 1, output pixel valid
- out_ready, input, 1, downstream accepts
- out_data, output, 2*BITS, upsampled pixel, row-major
- out_sol, output, 1, qualifies out_data as column 0 of an output row
- out_last, output, 1, qualifies out_data as the final pixel (DIM-1, DIM-1) of the frame

## Operation
- Counters:
  - in_col: 0..DIM/2-1
  - out_col: 0..DIM-1
  - row: 0..DIM/2-1, input row index
- Line buffer: DIM/2 entries x 2*BITS.
- FSM states:
  - FILL: in_ready=1, out_valid=0. On each accept (in_valid&in_ready), buf[in_col]<=in_data and in_col increments. The accept with in_col==DIM/2-1 clears in_col and moves to EMIT0.
  - EMIT0: out_valid=1, out_data=buf[out_col>>1]. On each transfer (out_valid&out_ready), out_col increments. The transfer with out_col==DIM-1 clears out_col and moves to EMIT1.
  - EMIT1: identical to EMIT0. The transfer with out_col==DIM-1 clears out_col, increments row (wrapping DIM/2-1 -> 0), and moves to FILL.
- out_sol = out_valid & (out_col==0).
- out_last = EMIT1 & (row==DIM/2-1) & (out_col==DIM-1).
- in_ready=0 in EMIT0/EMIT1. No overlap of fill and emit, so the buffer is never overwritten while being read.
- Data is passed bit-exact; no arithmetic, no sign handling.
- Frames are back-to-back; there is no frame-start input. Row wrap restarts the frame.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - state=FILL; in_col, out_col, row = 0
  - out_valid=0, out_sol=0, out_last=0, in_ready=0
  - in_ready is held at 0 for every cycle in which rst_n is sampled low, and rises the first cycle after reset deasserts.
- Buffer contents are not reset (don't-care).
- Reset mid-row or mid-emit discards the partial row and restarts at frame pixel (0,0). out_valid drops at the reset edge, even with a transfer pending.
- Latency: out_valid rises the cycle after the DIM/2-th accept of a row. in_ready rises the cycle after the final EMIT1 transfer.
- Full-rate throughput per input row: DIM/2 fill cycles + 2*DIM emit cycles.
- Output hold: while out_valid & ~out_ready, out_data, out_sol and out_last hold stable.
- out_valid never deasserts without a transfer, except on reset.
- Input stall: in_valid low in FILL simply waits; counters hold.
- Only one of accept or transfer is possible per cycle, by construction.

## Structure
- Shared package accel_pkg holds:
  - unpool_state_t enum {FILL, EMIT0, EMIT1}
  - pixel width localparam (2*BITS), shared with maxpool consumers
- Sub-module unpool_linebuf: DIM/2-entry register file.
  - One synchronous write port (we, waddr, wdata) and one combinational read port (raddr, rdata).
  - No reset.
- Top level holds the FSM, counters and flag logic.

## Test plan
- DIM=4, out_ready=1, input frame 1,2,3,4 -> output rows 1,1,2,2 / 1,1,2,2 / 3,3,4,4 / 3,3,4,4.
  - out_sol on beats 0,4,8,12; out_last only on beat 15.
  - out_valid rises the cycle after 2nd input accept.
- DIM=32, random 16-bit pixels, random in_valid and out_ready (50%) -> output matches the nearest-neighbour reference model over 3 back-to-back frames.
  - out_last exactly once per 1024 outputs.
- Backpressure: hold out_ready=0 for 5 cycles at EMIT0 out_col=3 -> out_data, out_sol, out_last stable; in_ready stays 0; no beat is lost or duplicated.
- Reset during EMIT1 of row 1 (DIM=4) -> next cycle out_valid=0 and in_ready=0 while reset is held, then in_ready=1. A fresh frame 9,8,7,6 produces 9,9,8,8 first.
- Reset mid-FILL after 1 accept, then new frame -> first output row is built from the post-reset pixels only.
- in_valid pulses with 3-cycle gaps during FILL -> no spurious accepts; output identical to the gapless case.
